// File: rtl/sr4_deser_pkg.sv
// Shared types and frame sizing for the sr4_deser receive stage.
// SR4_DESER_PARITY_EN appends one even-parity bit to every frame.
package sr4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 4;

`ifdef SR4_DESER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_len(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction

endpackage

// File: rtl/sr4_deser_sipo_shift.sv
// Right-shifting capture register: serial bits enter at the MSB and move toward bit 0.
// q_d_o exposes the next-state value so the completing bit is visible on its own edge.
module sipo_shift #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         din_i,
  output logic [N-1:0] q_d_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Clear also loads din so a start-of-frame bit is never lost.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = {din_i, {(N-1){1'b0}}};
    end else if (en_i) begin
      q_d = {din_i, q_q[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_d_o = q_d;

endmodule

// File: rtl/sr4_deser.sv
// Serial-to-parallel receive stage (LSB first) with valid/ready output and sticky error flags.
// Build option SR4_DESER_PARITY_EN adds a trailing even-parity bit per frame.
import sr4_pkg::*;

module sr4_deser #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err,
  input  logic             err_clr
);

  localparam int FL = frame_len(WIDTH);
  localparam int CW = $clog2(FL + 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dout_q;
  logic             dout_vld_q;
  logic             busy_q;
  logic             ovr_q;
  logic             perr_q;

  logic [FL-1:0]    frame_d;
  logic             start;
  logic             done;
  logic             par_bad;
  logic             ovr_set;
  logic             perr_set;

  always_comb begin
    start    = sin_vld && sof;
    done     = (state_q == SHIFT) && sin_vld && !sof && (cnt_q == CW'(FL - 1));
    ovr_set  = done && !par_bad && dout_vld_q && !dout_rdy;
    perr_set = done && par_bad;
  end

`ifdef SR4_DESER_PARITY_EN
  assign par_bad = ^frame_d;
`else
  assign par_bad = 1'b0;
`endif

  sipo_shift #(.N(FL)) u_sipo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (start),
    .en_i  (sin_vld && (state_q == SHIFT)),
    .din_i (sin),
    .q_d_o (frame_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(1);
          end
        end
        SHIFT: begin
          if (start) begin
            cnt_q <= CW'(1);
          end else if (done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (sin_vld) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase

      // A completing word may replace the held one only if the consumer takes it this edge.
      if (done && !par_bad && (!dout_vld_q || dout_rdy)) begin
        dout_q     <= frame_d[WIDTH-1:0];
        dout_vld_q <= 1'b1;
      end else if (dout_vld_q && dout_rdy) begin
        dout_vld_q <= 1'b0;
      end

      ovr_q  <= ovr_set  || (ovr_q  && !err_clr);
      perr_q <= perr_set || (perr_q && !err_clr);
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_sr4_deser.sv
// Directed-vector bench for sr4_deser; expected values are hand-computed per scenario.
// Define SR4_DESER_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_sr4_deser;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sin_vld;
  logic       sof;
  logic [3:0] dout;
  logic       dout_vld;
  logic       dout_rdy;
  logic       busy;
  logic       overrun;
  logic       parity_err;
  logic       err_clr;

  int n_total = 0;
  int n_bad   = 0;

  sr4_deser #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_vld    (sin_vld),
    .sof        (sof),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic drive(input logic s, input logic v, input logic f, input logic r);
    sin      = s;
    sin_vld  = v;
    sof      = f;
    dout_rdy = r;
    @(posedge clk);
    #1;
  endtask

  // Sends data LSB first (plus even parity in the parity build); rdy only on the last bit.
  task automatic send_word(input logic [3:0] data, input logic rdy_last);
    for (int i = 0; i < 4; i++) begin
`ifdef SR4_DESER_PARITY_EN
      drive(data[i], 1'b1, i == 0, 1'b0);
`else
      drive(data[i], 1'b1, i == 0, (i == 3) ? rdy_last : 1'b0);
`endif
    end
`ifdef SR4_DESER_PARITY_EN
    drive(^data, 1'b1, 1'b0, rdy_last);
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    sin      = 1'b0;
    sin_vld  = 1'b0;
    sof      = 1'b0;
    dout_rdy = 1'b0;
    err_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", {4'h0, dout}, 8'h00);
    chk("rst_vld", {7'h0, dout_vld}, 8'h00);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_ovr", {7'h0, overrun}, 8'h00);
    chk("rst_perr", {7'h0, parity_err}, 8'h00);

    // Basic word 1,0,1,1 -> 4'hD, valid for exactly one cycle after the last bit
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("basic_busy", {7'h0, busy}, 8'h01);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("basic_vld_early", {7'h0, dout_vld}, 8'h00);
`ifdef SR4_DESER_PARITY_EN
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("basic_vld_pre_par", {7'h0, dout_vld}, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
`else
    drive(1'b1, 1'b1, 1'b0, 1'b1);
`endif
    chk("basic_dout", {4'h0, dout}, 8'h0D);
    chk("basic_vld", {7'h0, dout_vld}, 8'h01);
    chk("basic_idle", {7'h0, busy}, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_vld_drop", {7'h0, dout_vld}, 8'h00);

    // Same word with idle gaps; capture holds and busy stays high
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("gap_busy1", {7'h0, busy}, 8'h01);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("gap_busy2", {7'h0, busy}, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("gap_vld_early", {7'h0, dout_vld}, 8'h00);
`ifdef SR4_DESER_PARITY_EN
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
`else
    drive(1'b1, 1'b1, 1'b0, 1'b1);
`endif
    chk("gap_dout", {4'h0, dout}, 8'h0D);
    chk("gap_vld", {7'h0, dout_vld}, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: 4'h3 held, 4'hC dropped
    send_word(4'h3, 1'b0);
    chk("ovr_first", {4'h0, dout}, 8'h03);
    send_word(4'hC, 1'b0);
    chk("ovr_dout", {4'h0, dout}, 8'h03);
    chk("ovr_vld", {7'h0, dout_vld}, 8'h01);
    chk("ovr_flag", {7'h0, overrun}, 8'h01);
    err_clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("ovr_clr", {7'h0, overrun}, 8'h00);
    chk("ovr_hold", {3'h0, dout_vld, dout}, 8'h13);

    // Accept on the completion edge: new word replaces the held one without overrun
    send_word(4'hC, 1'b1);
    chk("acc_dout", {4'h0, dout}, 8'h0C);
    chk("acc_vld", {7'h0, dout_vld}, 8'h01);
    chk("acc_ovr", {7'h0, overrun}, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("acc_drain", {7'h0, dout_vld}, 8'h00);

    // Back-to-back frames with no gap
    send_word(4'h5, 1'b1);
    chk("b2b_first", {3'h0, dout_vld, dout}, 8'h15);
    send_word(4'hA, 1'b1);
    chk("b2b_second", {3'h0, dout_vld, dout}, 8'h1A);
    chk("b2b_ovr", {7'h0, overrun}, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Resync: partial 1,1 discarded, then 0,0,1,0 -> 4'h4
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    send_word(4'h4, 1'b1);
    chk("resync_dout", {3'h0, dout_vld, dout}, 8'h14);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame: everything clears and trailing bits are ignored
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out", {2'h0, busy, dout_vld, dout}, 8'h00);
    chk("mrst_flags", {6'h0, overrun, parity_err}, 8'h00);
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mrst_nodata", {2'h0, busy, dout_vld, dout}, 8'h00);

`ifdef SR4_DESER_PARITY_EN
    // Good parity then bad parity on data 4'hD
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_ok", {3'h0, dout_vld, dout}, 8'h1D);
    chk("par_ok_err", {7'h0, parity_err}, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("par_bad_err", {7'h0, parity_err}, 8'h01);
    chk("par_bad_vld", {7'h0, dout_vld}, 8'h00);
    err_clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("par_clr", {7'h0, parity_err}, 8'h00);
`else
    chk("nopar_err", {7'h0, parity_err}, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
